// File: rtl/path_request_ctrl.sv
// path_request_ctrl: sequences a path request to a soft CPU.
// Preloads start/end node and clears the result mailboxes in CPU data memory
// while holding the CPU in reset. It then releases the CPU and snoops its
// stores to collect path nodes and detect the completion flag.
// Optional feature: define PATH_CTRL_TIMEOUT_EN to abort RUN after
// TIMEOUT_CYCLES cycles through the ERR state.
// The read port is 4 bits wide, so MAX_NODES is expected to be at most 16.
module path_request_ctrl #(
    parameter int unsigned MAX_NODES      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_50M,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  sp,
    input  logic [4:0]  ep,
    output logic        cpu_reset,
    output logic        ext_memwrite,
    output logic [31:0] ext_dataadr,
    output logic [31:0] ext_writedata,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_dataadr,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  rd_idx,
    output logic [4:0]  rd_node,
    output logic        busy,
    output logic [4:0]  path_len,
    output logic        path_found,
    output logic        overflow,
    output logic        timeout,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LD_SP,
        LD_EP,
        CLR_NODE,
        CLR_DONE,
        RUN,
        FIN,
        ERR
    } state_t;

    localparam logic [31:0] ADDR_SP   = 32'h0200_0000;
    localparam logic [31:0] ADDR_EP   = 32'h0200_0004;
    localparam logic [31:0] ADDR_NODE = 32'h0200_0008;
    localparam logic [31:0] ADDR_DONE = 32'h0200_000C;
    localparam logic [4:0]  MAX_LEN   = 5'(MAX_NODES);

    state_t      state;
    logic [4:0]  ep_q;
    logic [4:0]  buffer [16];
    logic        node_store;
    logic        done_store;
    logic        buf_wr;

    assign node_store = cpu_memwrite && (cpu_dataadr == ADDR_NODE);
    assign done_store = cpu_memwrite && (cpu_dataadr == ADDR_DONE) &&
                        (cpu_writedata == 32'd1);
    assign buf_wr     = (state == RUN) && node_store && (path_len < MAX_LEN);

`ifdef PATH_CTRL_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Control FSM; every output is registered together with the next state
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ep_q          <= '0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            path_len      <= '0;
            path_found    <= 1'b0;
            overflow      <= 1'b0;
            ext_memwrite  <= 1'b0;
            ext_dataadr   <= '0;
            ext_writedata <= '0;
`ifdef PATH_CTRL_TIMEOUT_EN
            timeout       <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            ext_memwrite  <= 1'b0;
            ext_dataadr   <= '0;
            ext_writedata <= '0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // sp is consumed directly by the first preload write
                        ep_q          <= ep;
                        path_len      <= '0;
                        path_found    <= 1'b0;
                        overflow      <= 1'b0;
`ifdef PATH_CTRL_TIMEOUT_EN
                        timeout       <= 1'b0;
`endif
                        busy          <= 1'b1;
                        state         <= LD_SP;
                        ext_memwrite  <= 1'b1;
                        ext_dataadr   <= ADDR_SP;
                        ext_writedata <= {27'b0, sp};
                    end
                end
                LD_SP: begin
                    state         <= LD_EP;
                    ext_memwrite  <= 1'b1;
                    ext_dataadr   <= ADDR_EP;
                    ext_writedata <= {27'b0, ep_q};
                end
                LD_EP: begin
                    state         <= CLR_NODE;
                    ext_memwrite  <= 1'b1;
                    ext_dataadr   <= ADDR_NODE;
                end
                CLR_NODE: begin
                    state         <= CLR_DONE;
                    ext_memwrite  <= 1'b1;
                    ext_dataadr   <= ADDR_DONE;
                end
                CLR_DONE: begin
                    state     <= RUN;
                    cpu_reset <= 1'b0;
`ifdef PATH_CTRL_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                RUN: begin
                    if (node_store) begin
                        if (path_len < MAX_LEN) begin
                            path_len <= path_len + 5'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (done_store) begin
                        path_found <= 1'b1;
                        done       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        state      <= FIN;
`ifdef PATH_CTRL_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        timeout    <= 1'b1;
                        cpu_reset  <= 1'b1;
                        state      <= ERR;
                    end else begin
                        tmo_cnt    <= tmo_cnt + 32'd1;
`endif
                    end
                end
                FIN, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cpu_reset <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Path buffer write; contents need no reset since path_len bounds validity
    always_ff @(posedge clk_50M) begin
        if (buf_wr) begin
            buffer[path_len[3:0]] <= cpu_writedata[4:0];
        end
    end

    assign rd_node = buffer[rd_idx];

endmodule

// File: tb/tb_path_request_ctrl.sv
// Self-checking bench for path_request_ctrl: preload writes go through an
// expected-write queue, node stores push expected buffer contents.
module tb_path_request_ctrl;

    logic        clk_50M = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  sp = '0;
    logic [4:0]  ep = '0;
    logic        cpu_reset;
    logic        ext_memwrite;
    logic [31:0] ext_dataadr;
    logic [31:0] ext_writedata;
    logic        cpu_memwrite = 1'b0;
    logic [31:0] cpu_dataadr = '0;
    logic [31:0] cpu_writedata = '0;
    logic [3:0]  rd_idx = '0;
    logic [4:0]  rd_node;
    logic        busy;
    logic [4:0]  path_len;
    logic        path_found;
    logic        overflow;
    logic        timeout;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    wr_t        sb_wr[$];
    logic [4:0] exp_nodes[$];

    localparam logic [31:0] A_SP   = 32'h0200_0000;
    localparam logic [31:0] A_EP   = 32'h0200_0004;
    localparam logic [31:0] A_NODE = 32'h0200_0008;
    localparam logic [31:0] A_DONE = 32'h0200_000C;

    path_request_ctrl #(
        .MAX_NODES      (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_50M       (clk_50M),
        .reset_n       (reset_n),
        .start         (start),
        .sp            (sp),
        .ep            (ep),
        .cpu_reset     (cpu_reset),
        .ext_memwrite  (ext_memwrite),
        .ext_dataadr   (ext_dataadr),
        .ext_writedata (ext_writedata),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_dataadr   (cpu_dataadr),
        .cpu_writedata (cpu_writedata),
        .rd_idx        (rd_idx),
        .rd_node       (rd_node),
        .busy          (busy),
        .path_len      (path_len),
        .path_found    (path_found),
        .overflow      (overflow),
        .timeout       (timeout),
        .done          (done)
    );

    always #10 clk_50M = ~clk_50M;

    // Preload-write monitor: every ext write must match the head of the queue
    always @(negedge clk_50M) begin
        if (ext_memwrite === 1'b1) begin
            wr_t e;
            n_checks++;
            if (sb_wr.size() == 0) begin
                n_fail++;
                $display("FAIL ext_write_unexpected: got %h/%h, required no write",
                         ext_dataadr, ext_writedata);
            end else begin
                e = sb_wr.pop_front();
                if (ext_dataadr !== e.adr || ext_writedata !== e.dat) begin
                    n_fail++;
                    $display("FAIL ext_write: got %h/%h, required %h/%h",
                             ext_dataadr, ext_writedata, e.adr, e.dat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic cpu_store(input logic [31:0] adr, input logic [31:0] dat);
        cpu_memwrite  = 1'b1;
        cpu_dataadr   = adr;
        cpu_writedata = dat;
        tick();
        cpu_memwrite  = 1'b0;
        cpu_dataadr   = '0;
        cpu_writedata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({cpu_reset, busy, done, path_found, overflow, timeout, ext_memwrite} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 1000000",
                     {cpu_reset, busy, done, path_found, overflow, timeout, ext_memwrite});
        end
        n_checks++;
        if (path_len !== 5'd0 || ext_dataadr !== 32'd0 || ext_writedata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: got len=%0d adr=%h dat=%h, required 0/0/0",
                     path_len, ext_dataadr, ext_writedata);
        end
        reset_n = 1'b1;
        tick();
    endtask

    // Accepts a request and walks the four preload cycles into RUN
    task automatic test_launch(input logic [4:0] s, input logic [4:0] e);
        sb_wr.push_back('{A_SP, {27'b0, s}});
        sb_wr.push_back('{A_EP, {27'b0, e}});
        sb_wr.push_back('{A_NODE, 32'd0});
        sb_wr.push_back('{A_DONE, 32'd0});
        sp    = s;
        ep    = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        sp    = 5'd31;
        ep    = 5'd31;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ext_memwrite !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL launch_preload_%0d: got we=%b rst=%b busy=%b, required 1/1/1",
                         i, ext_memwrite, cpu_reset, busy);
            end
            tick();
        end
        n_checks++;
        if (ext_memwrite !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b1 || ext_dataadr !== 32'd0) begin
            n_fail++;
            $display("FAIL launch_run_entry: got we=%b rst=%b busy=%b adr=%h, required 0/0/1/0",
                     ext_memwrite, cpu_reset, busy, ext_dataadr);
        end
    endtask

    task automatic node_store(input logic [4:0] v, input bit keep);
        if (keep) exp_nodes.push_back(v);
        cpu_store(A_NODE, {27'b0, v});
    endtask

    task automatic finish_done(input string tag);
        cpu_store(A_DONE, 32'd1);
        n_checks++;
        if (done !== 1'b1 || path_found !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_fin: got done=%b found=%b rst=%b busy=%b, required 1/1/1/1",
                     tag, done, path_found, cpu_reset, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || path_found !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: got done=%b busy=%b found=%b, required 0/0/1",
                     tag, done, busy, path_found);
        end
    endtask

    task automatic check_buffer(input string tag);
        int n;
        n = exp_nodes.size();
        for (int i = 0; i < n; i++) begin
            logic [4:0] e;
            e = exp_nodes.pop_front();
            rd_idx = 4'(i);
            #1;
            n_checks++;
            if (rd_node !== e) begin
                n_fail++;
                $display("FAIL %s_rd[%0d]: got %0d, required %0d", tag, i, rd_node, e);
            end
        end
    endtask

    task automatic test_path();
        test_launch(5'd8, 5'd17);
        node_store(5'd8, 1'b1);
        node_store(5'd9, 1'b1);
        cpu_store(32'h0200_0010, 32'd5);
        node_store(5'd13, 1'b1);
        node_store(5'd17, 1'b1);
        finish_done("path");
        n_checks++;
        if (path_len !== 5'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL path_len: got len=%0d ovf=%b, required 4/0", path_len, overflow);
        end
        tick();
        tick();
        n_checks++;
        if (path_len !== 5'd4 || path_found !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL path_hold: got len=%0d found=%b rst=%b done=%b, required 4/1/1/0",
                     path_len, path_found, cpu_reset, done);
        end
        check_buffer("path");
    endtask

    task automatic test_overflow();
        test_launch(5'd1, 5'd2);
        n_checks++;
        if (path_len !== 5'd0 || path_found !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: got len=%0d found=%b, required 0/0", path_len, path_found);
        end
        for (int i = 0; i < 16; i++) node_store(5'(i + 1), 1'b1);
        n_checks++;
        if (path_len !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got len=%0d ovf=%b, required 16/0", path_len, overflow);
        end
        node_store(5'd17, 1'b0);
        n_checks++;
        if (path_len !== 5'd16 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: got len=%0d ovf=%b, required 16/1", path_len, overflow);
        end
        finish_done("ovf");
        check_buffer("ovf");
    endtask

    task automatic test_ignore_start();
        test_launch(5'd3, 5'd5);
        cpu_store(A_DONE, 32'd2);
        n_checks++;
        if (done !== 1'b0 || path_found !== 1'b0 || cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_done2: got done=%b found=%b rst=%b, required 0/0/0",
                     done, path_found, cpu_reset);
        end
        sp    = 5'd20;
        ep    = 5'd21;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (cpu_reset !== 1'b0 || busy !== 1'b1 || ext_memwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_start: got rst=%b busy=%b we=%b, required 0/1/0",
                     cpu_reset, busy, ext_memwrite);
        end
        finish_done("ign");
    endtask

    task automatic test_timeout();
`ifdef PATH_CTRL_TIMEOUT_EN
        int cyc;
        test_launch(5'd4, 5'd6);
        cyc = 0;
        while (cpu_reset !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 100 || timeout !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_err: got cycles=%0d tmo=%b done=%b busy=%b, required 100/1/0/1",
                     cyc, timeout, done, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_idle: got busy=%b done=%b tmo=%b, required 0/0/1", busy, done, timeout);
        end
        // done store on the final allowed cycle takes priority over timeout
        test_launch(5'd4, 5'd6);
        for (int i = 0; i < 99; i++) tick();
        finish_done("tmo_edge");
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_edge_flag: got %b, required 0", timeout);
        end
`else
        test_launch(5'd4, 5'd6);
        for (int i = 0; i < 150; i++) tick();
        n_checks++;
        if (cpu_reset !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL no_tmo: got rst=%b busy=%b tmo=%b, required 0/1/0", cpu_reset, busy, timeout);
        end
        finish_done("no_tmo");
`endif
    endtask

    task automatic test_reset_mid_run();
        test_launch(5'd10, 5'd11);
        node_store(5'd1, 1'b0);
        node_store(5'd2, 1'b0);
        node_store(5'd3, 1'b0);
        n_checks++;
        if (path_len !== 5'd3) begin
            n_fail++;
            $display("FAIL mid_len: got %0d, required 3", path_len);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (path_len !== 5'd0 || cpu_reset !== 1'b1 || busy !== 1'b0 || path_found !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got len=%0d rst=%b busy=%b found=%b, required 0/1/0/0",
                     path_len, cpu_reset, busy, path_found);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (path_len !== 5'd0 || cpu_reset !== 1'b1 || busy !== 1'b0 || ext_memwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got len=%0d rst=%b busy=%b we=%b, required 0/1/0/0",
                     path_len, cpu_reset, busy, ext_memwrite);
        end
    endtask

    task automatic test_back_to_back();
        test_launch(5'd30, 5'd0);
        node_store(5'd21, 1'b1);
        finish_done("b2b");
        n_checks++;
        if (path_len !== 5'd1) begin
            n_fail++;
            $display("FAIL b2b_len: got %0d, required 1", path_len);
        end
        check_buffer("b2b");
    endtask

    initial begin
        test_reset();
        test_path();
        test_overflow();
        test_ignore_start();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        tick();
        n_checks++;
        if (sb_wr.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", sb_wr.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/path_request_ctrl.md
PATH_REQUEST_CTRL -- requirements
Module: path_request_ctrl

Interface
REQ-001 SHALL have parameter MAX_NODES, default 16: path buffer depth.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000: RUN cycle limit in clk_50M cycles.
REQ-003 SHALL have port clk_50M, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request pulse; sampled only in IDLE.
REQ-006 SHALL have ports sp and ep, input, 5 each: start and end node; captured when start is accepted.
REQ-007 SHALL have port cpu_reset, output, 1: holds the CPU in reset while high.
REQ-008 SHALL have ports ext_memwrite (1), ext_dataadr (32) and ext_writedata (32), outputs: CPU data-memory preload port.
REQ-009 SHALL have ports cpu_memwrite (1), cpu_dataadr (32) and cpu_writedata (32), inputs: CPU store snoop.
REQ-010 SHALL have port rd_idx, input, 4, and port rd_node, output, 5: combinational path buffer read.
REQ-011 SHALL have outputs busy (1), path_len (5), path_found (1), overflow (1), timeout (1) and done (1): status.

Function
REQ-012 SHALL implement FSM states IDLE, LD_SP, LD_EP, CLR_NODE, CLR_DONE, RUN, FIN and ERR.
REQ-013 SHALL move IDLE->LD_SP on start=1: latch sp/ep, clear path_len, path_found, overflow and timeout.
REQ-014 SHALL spend exactly one cycle in each of LD_SP, LD_EP, CLR_NODE and CLR_DONE, then enter RUN.
REQ-015 SHALL drive ext_memwrite=1 with these address/data pairs: LD_SP 0x02000000/{27'b0,sp}; LD_EP 0x02000004/{27'b0,ep}; CLR_NODE 0x02000008/0; CLR_DONE 0x0200000C/0.
REQ-016 SHALL drive ext_memwrite=0, ext_dataadr=0 and ext_writedata=0 in all other states.
REQ-017 SHALL drive cpu_reset=1 in every state except RUN, so the CPU is released on the first RUN cycle.
REQ-018 SHALL, in RUN, on cpu_memwrite=1 with cpu_dataadr=0x02000008, store cpu_writedata[4:0] at buffer[path_len] and increment path_len if path_len<MAX_NODES.
REQ-019 SHALL, when such a store occurs with path_len=MAX_NODES, drop the store, set overflow=1 and leave path_len unchanged.
REQ-020 SHALL, in RUN, on cpu_memwrite=1 with cpu_dataadr=0x0200000C and cpu_writedata=1, set path_found=1 and enter FIN.
REQ-021 SHALL ignore a done store with any cpu_writedata other than 1, and ignore stores to any other address.
REQ-022 SHALL assert done=1 for exactly the one FIN cycle, then return to IDLE.
REQ-023 SHALL make rd_node equal to buffer[rd_idx]; entries at index >= path_len are don't-care.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL hold path_found, path_len, overflow and timeout until the next accepted start.
REQ-027 SHALL leave ERR for IDLE after one cycle; done stays 0 on that path.

Reset
REQ-028 SHALL, while reset_n=0 (including mid-operation), force: state=IDLE; cpu_reset=1; busy, done, path_found, overflow, timeout, ext_memwrite=0; path_len=0; ext_dataadr=0; ext_writedata=0; timeout counter=0.
REQ-029 SHALL NOT require the buffer contents to be reset.

Configuration
REQ-030 SHALL, with macro PATH_CTRL_TIMEOUT_EN defined, count RUN cycles from 0 at RUN entry.
REQ-031 SHALL, with PATH_CTRL_TIMEOUT_EN defined, enter ERR and set timeout=1 when the count reaches TIMEOUT_CYCLES-1 with no done store that cycle; a done store in that same cycle wins.
REQ-032 SHALL, without PATH_CTRL_TIMEOUT_EN, omit the counter, tie timeout to 0 and stay in RUN until the done store.

Verification
REQ-033 SHALL be verified by: start with sp=8, ep=17 -> ext writes 0x02000000/8, 0x02000004/17, 0x02000008/0, 0x0200000C/0 on 4 consecutive cycles; cpu_reset falls on the next cycle.
REQ-034 SHALL be verified by: in RUN, node stores 8,9,13,17 then store 0x0200000C/1 -> path_len=4; rd_idx 0..3 gives 8,9,13,17; done is a 1-cycle pulse; path_found=1; cpu_reset=1.
REQ-035 SHALL be verified by: 17 node stores with MAX_NODES=16 -> path_len=16, overflow=1, buffer[15] holds the 16th value.
REQ-036 SHALL be verified by: store 0x0200000C/2, then a start pulse while in RUN -> state stays RUN and sp/ep are not re-latched.
REQ-037 SHALL be verified by: PATH_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, no done store -> ERR after 100 RUN cycles, timeout=1, done stays 0.
REQ-038 SHALL be verified by: reset_n low for 1 cycle mid-RUN after 3 node stores -> IDLE, path_len=0, cpu_reset=1, busy=0.
